// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phy_pkg
// Description : Shared PHY constants and the deserializer/serializer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package phy_pkg;

    localparam logic [7:0] COMMA_BC           = 8'hBC;
    localparam int         DEFAULT_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } deser_state_t;

endpackage
`default_nettype wire

// File: rtl/comma_detector.sv
`default_nettype none
// ============================================================================
// Module      : comma_detector
// Description : Serial shift register exposing the candidate byte (including the
//               bit on the wire this cycle) and its comparison against COMMA.
// Revision    : 1.0 - initial release
// ============================================================================
module comma_detector
    import phy_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter logic [DATA_W-1:0] COMMA = COMMA_BC
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [DATA_W-1:0] cand,
    output logic              is_comma
);

    logic [DATA_W-1:0] r_sh;

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[DATA_W-2:0], data_in};
        end
    end

    // The candidate already holds the incoming bit so a match is seen on the LSB edge.
    assign cand     = {r_sh[DATA_W-2:0], data_in};
    assign is_comma = (cand == COMMA);

endmodule
`default_nettype wire

// File: rtl/serial_paralelo_8b.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_8b
// Description : Comma-aligned serial-to-parallel deserializer; presents one byte
//               and a payload flag every 8 clocks once lock is achieved.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_8b
    import phy_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] COMMA      = COMMA_BC,
    parameter int                LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);

    localparam logic [3:0] c_LOCK_CNT = 4'(LOCK_COUNT);

    deser_state_t      r_state;
    deser_state_t      w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_cnt_nxt;
    logic [3:0]        r_comma_cnt;
    logic [3:0]        w_comma_cnt_nxt;
    logic [3:0]        w_comma_inc;
    logic [DATA_W-1:0] r_data_out;
    logic [DATA_W-1:0] w_data_nxt;
    logic              r_valid_out;
    logic              w_valid_nxt;
    logic [DATA_W-1:0] w_cand;
    logic              w_is_comma;
    logic              w_boundary;

    comma_detector #(
        .DATA_W (DATA_W),
        .COMMA  (COMMA)
    ) u_comma_detector (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .cand     (w_cand),
        .is_comma (w_is_comma)
    );

    assign w_boundary  = (r_bit_cnt == 3'd7);
    assign w_comma_inc = r_comma_cnt + 4'd1;

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= SEARCH;
            r_bit_cnt   <= 3'd0;
            r_comma_cnt <= 4'd0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_comma_cnt <= w_comma_cnt_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
        w_comma_cnt_nxt = r_comma_cnt;
        w_data_nxt      = r_data_out;
        w_valid_nxt     = r_valid_out;
        case (r_state)
            SEARCH: begin
                // Bit-sliding search: a hit fixes the byte phase from this edge on.
                if (w_is_comma) begin
                    w_bit_cnt_nxt   = 3'd0;
                    w_comma_cnt_nxt = 4'd1;
                    w_state_nxt     = (c_LOCK_CNT == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_comma_cnt_nxt = w_comma_inc;
                        if (w_comma_inc == c_LOCK_CNT) begin
                            w_state_nxt = ACTIVE;
                        end
                    end else begin
                        w_comma_cnt_nxt = 4'd0;
                        w_state_nxt     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (w_boundary) begin
                    w_data_nxt  = w_cand;
                    w_valid_nxt = !w_is_comma;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign active    = (r_state == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_8b.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo_8b
// Description : Scoreboard bench for serial_paralelo_8b (LOCK_COUNT 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_8b;

    typedef struct packed {
        logic       act;
        logic       vld;
        logic [7:0] dat;
        logic       act1;
    } exp_t;

    logic       clk_32f;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [7:0] data_out1;
    logic       valid_out1;
    logic       active1;

    exp_t       exp_q[$];
    exp_t       cur;
    int         n_checks;
    int         n_fail;

    serial_paralelo_8b #(
        .DATA_W     (8),
        .COMMA      (8'hBC),
        .LOCK_COUNT (4)
    ) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    serial_paralelo_8b #(
        .DATA_W     (8),
        .COMMA      (8'hBC),
        .LOCK_COUNT (1)
    ) dut1 (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out1),
        .valid_out (valid_out1),
        .active    (active1)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic check(input string name, input exp_t e);
        exp_t got;
        got = '{act: active, vld: valid_out, dat: data_out, act1: active1};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t: got act=%b vld=%b dat=%h act1=%b, expected act=%b vld=%b dat=%h act1=%b",
                     name, $time, got.act, got.vld, got.dat, got.act1, e.act, e.vld, e.dat, e.act1);
        end
    endtask

    // Monitor: one expectation per clock, compared away from the active edge.
    always @(negedge clk_32f) begin
        if (exp_q.size() > 0) begin
            check("cycle", exp_q.pop_front());
        end
    end

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        exp_q.push_back(cur);
    endtask

    // Expected outputs take their new values on the byte's LSB edge.
    task automatic send_byte(input logic [7:0] b, input logic na, input logic nv,
                             input logic [7:0] nd, input logic na1);
        for (int i = 7; i >= 0; i--) begin
            data_in = b[i];
            @(posedge clk_32f);
            #1;
            if (i == 0) cur = '{act: na, vld: nv, dat: nd, act1: na1};
            exp_q.push_back(cur);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        #1;
        reset_L = 1'b0;
        cur     = '0;
        #1;
        check("reset_state", cur);
        repeat (2) @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cur      = '0;
        data_in  = 1'b0;
        reset_L  = 1'b0;
        repeat (2) @(negedge clk_32f);
        reset_L = 1'b1;

        // Zero-offset lock: active rises on clock 32, outputs stay idle.
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 1, 0, 8'h00, 1);

        // 3-bit phase offset, then payload; continues into mixed payload/comma.
        do_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 1, 0, 8'h00, 1);
        send_byte(8'h12, 1, 1, 8'h12, 1);
        send_byte(8'h34, 1, 1, 8'h34, 1);
        send_byte(8'hA5, 1, 1, 8'hA5, 1);
        send_byte(8'hBC, 1, 0, 8'hBC, 1);
        send_byte(8'h5A, 1, 1, 8'h5A, 1);

        // Broken comma run restarts the search.
        do_reset();
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'h55, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 1, 0, 8'h00, 1);
        send_byte(8'h77, 1, 1, 8'h77, 1);

        // Mid-byte asynchronous reset while locked.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk_32f);
        #2;
        reset_L = 1'b0;
        cur     = '0;
        #1;
        check("async_reset", cur);
        @(negedge clk_32f);
        reset_L = 1'b1;
        send_byte(8'h66, 0, 0, 8'h00, 0);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 0, 0, 8'h00, 1);
        send_byte(8'hBC, 1, 0, 8'h00, 1);
        send_byte(8'h99, 1, 1, 8'h99, 1);

        repeat (2) @(negedge clk_32f);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
